// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the trap controller: register map, trap-entry address, FSM encodings.
package trap_ctrl_pkg;

    localparam logic [31:0] TRAPC_BASE = 32'h0000_0200;
    // Address of the core's trap-entry store; kept outside the register window.
    localparam logic [31:0] TRAP_ADDR  = 32'h0000_0100;

    typedef logic [2:0] reg_off_t;

    localparam reg_off_t TRAPC_PEND  = 3'd0;
    localparam reg_off_t TRAPC_ENAB  = 3'd1;
    localparam reg_off_t TRAPC_ACTV  = 3'd2;
    localparam reg_off_t TRAPC_EPC   = 3'd3;
    localparam reg_off_t TRAPC_CAUSE = 3'd4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

endpackage

// File: rtl/trap_ctrl_if.sv
// Core data-bus view seen by the trap controller (snooped stores plus register reads).
interface trap_ctrl_if;
    logic        strobe;
    logic        mem_rw;
    logic [31:0] d_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;

    modport master (output strobe, mem_rw, d_addr, wdata, input rdata, sel);
    modport slave  (input strobe, mem_rw, d_addr, wdata, output rdata, sel);
endinterface

// File: rtl/trap_ctrl_prio.sv
// Lowest-set-bit encoder used to pick the serviced interrupt source.
module trap_prio #(
    parameter int NIRQ = 8
) (
    input  logic [NIRQ-1:0] i_req,
    output logic [4:0]      o_idx,
    output logic            o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = 5'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Interrupt/trap controller: edge-detected pending latch, enable mask, trap handshake
// via snooped trap-entry store, and a small memory-mapped register window.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int          NIRQ = 8,
    parameter logic [31:0] BASE = TRAPC_BASE
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NIRQ-1:0] i_irq,
    trap_ctrl_if.slave      bus,
    output logic            o_trap
);

    logic [NIRQ-1:0] r_irq_q;
    logic [NIRQ-1:0] r_pending;
    logic [NIRQ-1:0] r_enable;
    logic [NIRQ-1:0] r_active;
    logic [31:0]     r_epc;
    logic [4:0]      r_cause;
    logic            r_trap;
    logic [1:0]      r_state;

    logic [31:0]     w_off;
    logic            w_hit;
    reg_off_t        w_roff;
    logic            w_wr;
    logic            w_wr_pend;
    logic            w_wr_enab;
    logic            w_wr_actv;
    logic [NIRQ-1:0] w_rise;
    logic [NIRQ-1:0] w_pe;
    logic [4:0]      w_idx;
    logic            w_valid;
    logic            w_capture;
    logic [NIRQ-1:0] w_onehot;
    logic [NIRQ-1:0] w_w1c;
    logic [NIRQ-1:0] w_pend_nxt;

    assign w_off  = bus.d_addr - BASE;
    assign w_hit  = (w_off < 32'd5);
    assign w_roff = w_off[2:0];
    assign w_wr   = bus.strobe & bus.mem_rw;

    assign w_wr_pend = w_wr & w_hit & (w_roff == TRAPC_PEND);
    assign w_wr_enab = w_wr & w_hit & (w_roff == TRAPC_ENAB);
    assign w_wr_actv = w_wr & w_hit & (w_roff == TRAPC_ACTV);

    assign w_rise = i_irq & ~r_irq_q;
    assign w_pe   = r_pending & r_enable;

    trap_prio #(.NIRQ(NIRQ)) u_prio (
        .i_req   (w_pe),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_capture = (r_state == ST_REQ) & w_wr & (bus.d_addr == TRAP_ADDR) & w_valid;
    assign w_onehot  = NIRQ'(1) << w_idx;
    assign w_w1c     = w_wr_pend ? bus.wdata[NIRQ-1:0] : '0;

    // New edges are OR-ed in last so they survive both W1C and capture clears.
    assign w_pend_nxt = (r_pending & ~w_w1c & ~(w_capture ? w_onehot : '0)) | w_rise;

    assign bus.sel = bus.strobe & ~bus.mem_rw & w_hit;

    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (w_roff)
                TRAPC_PEND:  bus.rdata = 32'(r_pending);
                TRAPC_ENAB:  bus.rdata = 32'(r_enable);
                TRAPC_ACTV:  bus.rdata = 32'(r_active);
                TRAPC_EPC:   bus.rdata = r_epc;
                TRAPC_CAUSE: bus.rdata = 32'(r_cause);
                default:     bus.rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq_q   <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_active  <= '0;
            r_epc     <= '0;
            r_cause   <= '0;
            r_trap    <= 1'b0;
            r_state   <= ST_IDLE;
        end else begin
            r_irq_q   <= i_irq;
            r_pending <= w_pend_nxt;
            if (w_wr_enab) r_enable <= bus.wdata[NIRQ-1:0];
            if (w_wr_actv) r_active <= '0;

            case (r_state)
                ST_IDLE: begin
                    if ((|w_pe) && (r_active == '0)) begin
                        r_state <= ST_REQ;
                        r_trap  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (w_capture) begin
                        r_epc    <= bus.wdata;
                        r_cause  <= w_idx;
                        r_active <= w_onehot;
                        r_trap   <= 1'b0;
                        r_state  <= ST_SERVICE;
                    end else if (!(|w_pe)) begin
                        r_trap  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (w_wr_actv) r_state <= ST_IDLE;
                end
                default: begin
                    r_trap  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_trap = r_trap;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: register-map table plus hand-written trap sequences.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam logic [31:0] BASE = TRAPC_BASE;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          exp_sel;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] irq;
    logic       trap;
    int         n_tests;
    int         n_fail;
    vec_t       tbl[15];

    trap_ctrl_if bus ();

    trap_ctrl #(.NIRQ(8), .BASE(BASE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_irq   (irq),
        .bus     (bus),
        .o_trap  (trap)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.strobe = 1'b1;
        bus.mem_rw = 1'b1;
        bus.d_addr = addr;
        bus.wdata  = data;
        step();
        bus.strobe = 1'b0;
        bus.mem_rw = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp,
                          input bit exp_sel);
        bus.strobe = 1'b1;
        bus.mem_rw = 1'b0;
        bus.d_addr = addr;
        #1;
        check(name, bus.rdata, exp);
        check({name, "_sel"}, 32'(bus.sel), 32'(exp_sel));
        bus.strobe = 1'b0;
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] pend, input logic [31:0] actv,
                            input logic [31:0] epc, input logic [31:0] cause);
        rd_chk({tag, "_pend"},  BASE + 0, pend,  1'b1);
        rd_chk({tag, "_actv"},  BASE + 2, actv,  1'b1);
        rd_chk({tag, "_epc"},   BASE + 3, epc,   1'b1);
        rd_chk({tag, "_cause"}, BASE + 4, cause, 1'b1);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        irq        = '0;
        bus.strobe = 1'b0;
        bus.mem_rw = 1'b0;
        bus.d_addr = '0;
        bus.wdata  = '0;

        tbl[0]  = '{1'b1, BASE + 1, 32'h0000_00A5, 1'b0, 32'h0, "enab_wr"};
        tbl[1]  = '{1'b0, BASE + 1, 32'h0,         1'b1, 32'hA5, "enab_rd"};
        tbl[2]  = '{1'b1, BASE + 1, 32'hFFFF_FF3C, 1'b0, 32'h0, "enab_wr_wide"};
        tbl[3]  = '{1'b0, BASE + 1, 32'h0,         1'b1, 32'h3C, "enab_rd_trunc"};
        tbl[4]  = '{1'b1, BASE + 3, 32'hDEAD_BEEF, 1'b0, 32'h0, "epc_wr_ro"};
        tbl[5]  = '{1'b0, BASE + 3, 32'h0,         1'b1, 32'h0, "epc_rd_ro"};
        tbl[6]  = '{1'b1, BASE + 4, 32'h0000_001F, 1'b0, 32'h0, "cause_wr_ro"};
        tbl[7]  = '{1'b0, BASE + 4, 32'h0,         1'b1, 32'h0, "cause_rd_ro"};
        tbl[8]  = '{1'b0, BASE + 5, 32'h0,         1'b0, 32'h0, "above_window"};
        tbl[9]  = '{1'b0, BASE - 1, 32'h0,         1'b0, 32'h0, "below_window"};
        tbl[10] = '{1'b0, TRAP_ADDR, 32'h0,        1'b0, 32'h0, "trap_addr_rd"};
        tbl[11] = '{1'b1, BASE + 0, 32'h0000_00FF, 1'b0, 32'h0, "pend_w1c_empty"};
        tbl[12] = '{1'b0, BASE + 0, 32'h0,         1'b1, 32'h0, "pend_rd_empty"};
        tbl[13] = '{1'b1, BASE + 1, 32'h0,         1'b0, 32'h0, "enab_wr_zero"};
        tbl[14] = '{1'b0, BASE + 1, 32'h0,         1'b1, 32'h0, "enab_rd_zero"};

        step();
        step();
        check("reset_trap", 32'(trap), 32'h0);
        reset_n = 1'b1;
        step();
        chk_regs("reset", 32'h0, 32'h0, 32'h0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
            else rd_chk(tbl[i].name, tbl[i].addr, tbl[i].exp_rd, tbl[i].exp_sel);
        end
        check("tbl_no_trap", 32'(trap), 32'h0);

        // Single source, full trap handshake
        wr(BASE + 1, 32'h04);
        irq = 8'h04;
        step();
        irq = 8'h00;
        check("t1_trap_latency", 32'(trap), 32'h0);
        rd_chk("t1_pend", BASE + 0, 32'h04, 1'b1);
        step();
        check("t1_trap_high", 32'(trap), 32'h1);
        wr(TRAP_ADDR, 32'h0000_1234);
        check("t2_trap_low", 32'(trap), 32'h0);
        chk_regs("t2", 32'h00, 32'h04, 32'h1234, 32'd2);
        wr(BASE + 2, 32'h0);

        // Two simultaneous sources, lowest index first
        wr(BASE + 1, 32'hFF);
        irq = 8'h22;
        step();
        irq = 8'h00;
        step();
        check("t3_trap_first", 32'(trap), 32'h1);
        wr(TRAP_ADDR, 32'h0000_0100);
        chk_regs("t3a", 32'h20, 32'h02, 32'h0100, 32'd1);
        wr(BASE + 2, 32'h0);
        step();
        check("t3_trap_reassert", 32'(trap), 32'h1);
        wr(TRAP_ADDR, 32'h0000_5678);
        chk_regs("t3b", 32'h00, 32'h20, 32'h5678, 32'd5);
        wr(BASE + 2, 32'h0);

        // Rise vs W1C collision, then a held level
        wr(BASE + 1, 32'h00);
        irq = 8'h08;
        wr(BASE + 0, 32'h08);
        rd_chk("t4_set_wins", BASE + 0, 32'h08, 1'b1);
        for (int i = 0; i < 10; i++) step();
        wr(BASE + 0, 32'h08);
        step();
        step();
        rd_chk("t4_level_once", BASE + 0, 32'h00, 1'b1);
        irq = 8'h00;
        step();
        check("t4_no_trap", 32'(trap), 32'h0);

        // Masking during REQ withdraws the trap; stray capture store in IDLE ignored
        wr(BASE + 1, 32'h01);
        irq = 8'h01;
        step();
        irq = 8'h00;
        step();
        check("t5_trap_high", 32'(trap), 32'h1);
        wr(BASE + 1, 32'h00);
        step();
        check("t5_trap_dropped", 32'(trap), 32'h0);
        wr(TRAP_ADDR, 32'h0000_BEEF);
        check("t5_idle_store_trap", 32'(trap), 32'h0);
        chk_regs("t5", 32'h01, 32'h00, 32'h5678, 32'd5);

        // Reset while in SERVICE with another source pending
        wr(BASE + 1, 32'h01);
        step();
        check("t6_trap_high", 32'(trap), 32'h1);
        irq = 8'h10;
        step();
        irq = 8'h00;
        wr(TRAP_ADDR, 32'h0000_0055);
        chk_regs("t6_service", 32'h10, 32'h01, 32'h55, 32'd0);
        reset_n = 1'b0;
        step();
        check("t6_trap_reset", 32'(trap), 32'h0);
        check("t6_sel_reset", 32'(bus.sel), 32'h0);
        chk_regs("t6_in_reset", 32'h0, 32'h0, 32'h0, 32'h0);
        reset_n = 1'b1;
        step();
        step();
        chk_regs("t6_after", 32'h0, 32'h0, 32'h0, 32'h0);
        rd_chk("t6_enab", BASE + 1, 32'h0, 1'b1);
        check("t6_trap_after", 32'(trap), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
